divide_unit: RTL and testbench
==============================

Name: divide_unit

Overview:
- Iterative integer divider implementing the RV32M DIV, DIVU, REM and REMU operations.
- It is the sequential counterpart of the single-cycle arithmetic/logic unit: operands come from the register-read stage, and the execute stage stalls on busy until done.
- Radix-2 restoring algorithm with fixed latency for every operand combination, including the RISC-V special cases.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is verified.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only while busy=0
- op  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  in  WIDTH  dividend, sampled with start
- b  in  WIDTH  divisor, sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  single-cycle pulse: r is valid
- r  out  WIDTH  quotient or remainder; held from done until the next accepted start

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, r=0; iteration counter=0.
  - Any in-flight result is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at an edge accepts the request.
  - Latch op, sign flags and operand magnitudes:
    - Signed ops: |a| and |b|, two's complement, as WIDTH-bit unsigned values. |0x80000000| = 0x80000000.
    - Unsigned ops: a and b as-is.
  - Clear the partial remainder; counter=0; go to RUN.
  - busy=1 from the following cycle. done falls to 0 at the accept edge.
- RUN: one quotient bit per cycle, MSB first.
  - Shift {rem, dividend} left by 1.
  - Trial subtract the divisor from the WIDTH+1-bit partial remainder.
  - If the result is non-negative: keep it and set the quotient bit to 1. Otherwise restore and set the bit to 0.
  - After WIDTH iterations (counter reaches WIDTH-1), go to FIX.
- FIX: single cycle.
  - Signed ops with divisor nonzero:
    - Negate the quotient if sign(a) xor sign(b).
    - Negate the remainder if sign(a) (remainder takes the dividend's sign).
  - Divisor zero (all ops): quotient=all ones, remainder=a (original dividend). The raw algorithm already gives these for unsigned ops; FIX must not apply sign correction.
  - Overflow DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out naturally; no special path.
  - Select r: quotient for op[1]=0, remainder for op[1]=1.
  - done=1 and busy=0 for exactly one cycle; return to IDLE.
- Latency:
  - Start accepted at edge E0; done high in the cycle after edge E(WIDTH+1), i.e. E33 for WIDTH=32.
  - Fixed latency, independent of operand values.
- Back-to-back issue: start may be asserted in the done cycle. It is accepted at that edge (state is already IDLE); done drops and busy rises.
- Start while busy=1 is ignored; there is no queue.
- a, b and op may change freely after acceptance; only latched copies are used.
- r changes only in FIX and on reset.

Test Plan:
- DIVU a=100, b=7 -> busy high 33 cycles, done pulse 33 cycles after the accept edge, r=14. REMU same operands -> r=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> r=0xFFFFFFFD (-3). REM -> r=0xFFFFFFFF (-1). REM a=7, b=-2 -> r=1.
- Divide by zero: DIV/DIVU a=0x12345678, b=0 -> r=0xFFFFFFFF. REM/REMU -> r=0x12345678. DIV a=-5, b=0 -> r=0xFFFFFFFF.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000. REM -> r=0. DIVU same operands -> r=0.
- Handshake: start held high continuously with new operands -> start ignored while busy; a new op is accepted in each done cycle; a and b changed mid-RUN do not affect r.
- Reset asserted asynchronously mid-RUN (cycle 10) -> busy, done and r are 0 immediately; after release, a new DIVU 9/3 yields r=3 with standard latency.

Source files
------------

// File: rtl/divide_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: done pulses WIDTH+1 edges after the accept edge.
//
// state | meaning
// IDLE  | waiting for start; r holds last result
// RUN   | one quotient bit per cycle, MSB first
// FIX   | sign correction, result select, done pulse
module divide_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, r_q, r_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             is_signed, a_neg, b_neg, dvs_zero;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, rem_fix;
   logic [WIDTH:0]   rem_sh, trial;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      r_d     = r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      is_signed = ~op[0];
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;

      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, dvs_q};
      dvs_zero = (dvs_q == '0);

      // A zero divisor keeps the all-ones raw quotient; the remainder
      // correction then reproduces the original dividend on its own.
      q_fix   = ((sa_q ^ sb_q) && !dvs_zero) ? -quo_q : quo_q;
      rem_fix = sa_q ? -rem_q : rem_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               sa_d    = a_neg;
               sb_d    = b_neg;
               quo_d   = a_mag;
               dvs_d   = b_mag;
               rem_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIX: begin
            r_d     = op_q[1] ? rem_fix : q_fix;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign r    = r_q;

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: RV32M results, special cases,
// fixed latency, handshake and asynchronous reset.
module tb_divide_unit;
   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] r;

   int total;
   int passed;
   int n;

   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   divide_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .r     (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
   endtask

   // Called #1 after an edge; counts edges until done is seen, bounded.
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!done && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
      check({tag, " done@accept"}, {31'd0, done}, 32'd0);
      wait_done(cyc);
      check({tag, " latency"}, 32'(cyc), 32'd33);
      check({tag, " r"}, r, exp);
      check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      #3;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst r", r, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14);
      do_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2);
      do_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      do_op("rem -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      do_op("rem 7/-2", REM, 32'd7, 32'hFFFFFFFE, 32'd1);
      do_op("div 20/-3", DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA);
      do_op("rem 20/-3", REM, 32'd20, 32'hFFFFFFFD, 32'd2);
      do_op("rem -20/3", REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE);
      do_op("div x/0", DIV, 32'h12345678, 32'd0, 32'hFFFFFFFF);
      do_op("divu x/0", DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF);
      do_op("rem x/0", REM, 32'h12345678, 32'd0, 32'h12345678);
      do_op("remu x/0", REMU, 32'h12345678, 32'd0, 32'h12345678);
      do_op("div -5/0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
      do_op("rem -5/0", REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
      do_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      do_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      do_op("divu ovf", DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      do_op("remu ovf", REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);

      // Start held high: ignored while busy, re-accepted in the done cycle.
      @(negedge clk);
      start = 1'b1;
      op    = DIVU;
      a     = 32'd100;
      b     = 32'd7;
      @(posedge clk);
      #1;
      a = 32'd50;
      b = 32'd5;
      wait_done(n);
      check("hold latency1", 32'(n), 32'd33);
      check("hold r1", r, 32'd14);
      @(posedge clk);
      #1;
      check("hold done drop", {31'd0, done}, 32'd0);
      check("hold busy rise", {31'd0, busy}, 32'd1);
      check("hold r held", r, 32'd14);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      a     = 32'd1;
      b     = 32'd1;
      start = 1'b0;
      wait_done(n);
      check("hold latency2", 32'(n), 32'd28);
      check("hold r2", r, 32'd10);
      @(posedge clk);
      #1;
      check("done one cycle", {31'd0, done}, 32'd0);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      start = 1'b1;
      op    = DIVU;
      a     = 32'hFFFFFFFF;
      b     = 32'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      check("midrst r", r, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_op("divu 9/3", DIVU, 32'd9, 32'd3, 32'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
